// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM types and constants (FSM states, default width, prescaler select codes)
package pwm_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic [1:0] {PSC_DIV1, PSC_DIV2, PSC_DIV4, PSC_DIV8} psc_sel_t;
endpackage

// File: rtl/pwm_if.sv
// pwm_if: PWM control/status bundle; master drives en/tick/period/duty/load/polarity, slave returns pwm_out/cnt/period_end/pending
interface pwm_if import pwm_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();
  logic en;
  logic tick;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] duty;
  logic load;
  logic polarity;
  logic pwm_out;
  logic [WIDTH-1:0] cnt;
  logic period_end;
  logic pending;
  modport master (output en, tick, period, duty, load, polarity, input pwm_out, cnt, period_end, pending);
  modport slave (input en, tick, period, duty, load, polarity, output pwm_out, cnt, period_end, pending);
endinterface

// File: rtl/pwm_shadow_regs.sv
// pwm_shadow_regs: pending/active period+duty pair; load_i captures period_i/duty_i, apply_i promotes pending to active, outputs pend_o/per_a_o/duty_a_o
module pwm_shadow_regs import pwm_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             apply_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             pend_o,
  output logic [WIDTH-1:0] per_a_o,
  output logic [WIDTH-1:0] duty_a_o
);
  logic [WIDTH-1:0] per_p_q, per_p_d, duty_p_q, duty_p_d, per_a_q, per_a_d, duty_a_q, duty_a_d;
  logic pend_q, pend_d, go;
  assign go = apply_i && pend_q;
  always_comb begin
    per_p_d = load_i ? period_i : per_p_q;
    duty_p_d = load_i ? duty_i : duty_p_q;
    pend_d = load_i || (pend_q && !apply_i);
    per_a_d = go ? per_p_q : per_a_q;
    duty_a_d = go ? duty_p_q : duty_a_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      per_p_q <= '0;
      duty_p_q <= '0;
      pend_q <= 1'b0;
      per_a_q <= '1;
      duty_a_q <= '0;
    end else begin
      per_p_q <= per_p_d;
      duty_p_q <= duty_p_d;
      pend_q <= pend_d;
      per_a_q <= per_a_d;
      duty_a_q <= duty_a_d;
    end
  end
  assign pend_o = pend_q;
  assign per_a_o = per_a_q;
  assign duty_a_o = duty_a_q;
endmodule

// File: rtl/pwm_core.sv
// pwm_core: tick-driven period counter + duty comparator; ports clk, rst, bus (pwm_if.slave: en/tick/period/duty/load/polarity in, pwm_out/cnt/period_end/pending out)
module pwm_core import pwm_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic  clk,
  input logic  rst,
  pwm_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, per_a, duty_a;
  logic pwm_q, pwm_d, pe_q, pe_d, run, wrap, apply, pend;
  assign run = state_q == ST_RUN;
  assign wrap = run && bus.en && bus.tick && cnt_q == per_a;
  assign apply = bus.en && (!run || wrap);
  pwm_shadow_regs #(.WIDTH(WIDTH)) u_shadow (
    .clk(clk), .rst(rst), .load_i(bus.load), .apply_i(apply),
    .period_i(bus.period), .duty_i(bus.duty),
    .pend_o(pend), .per_a_o(per_a), .duty_a_o(duty_a)
  );
  always_comb begin
    state_d = bus.en ? ST_RUN : ST_IDLE;
    cnt_d = (!run || !bus.en || wrap) ? '0 : cnt_q + WIDTH'(bus.tick);
    pwm_d = run ? (cnt_q < duty_a) ^ bus.polarity : bus.polarity;
    pe_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      pwm_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      pe_q <= pe_d;
    end
  end
  assign bus.pwm_out = pwm_q;
  assign bus.cnt = cnt_q;
  assign bus.period_end = pe_q;
  assign bus.pending = pend;
endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed self-checking bench for pwm_core
module tb_pwm_core;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  pwm_if #(.WIDTH(8)) bus ();
  pwm_core #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input int per, input int dty);
    bus.en = 1'b0;
    bus.period = 8'(per);
    bus.duty = 8'(dty);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    bus.en = 1'b1;
    step();
  endtask
  task automatic run(input int n, input int per, input int dty, input int pol, input int j0);
    for (int k = 0; k < n; k++) begin
      int j;
      int nx;
      j = (j0 + k) % (per + 1);
      nx = (j + 1) % (per + 1);
      step();
      chk("pwm", int'(bus.pwm_out), int'(j < dty) ^ pol);
      chk("cnt", int'(bus.cnt), nx);
      chk("period_end", int'(bus.period_end), int'(nx == 0));
    end
  endtask
  initial begin
    int e;
    int pe_n;
    int pe_c[2];
    rst = 1'b1;
    bus.en = 1'b0;
    bus.tick = 1'b1;
    bus.period = '0;
    bus.duty = '0;
    bus.load = 1'b0;
    bus.polarity = 1'b1;
    step();
    step();
    chk("rst_pwm", int'(bus.pwm_out), 0);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_pending", int'(bus.pending), 0);
    rst = 1'b0;
    step();
    chk("idle_pwm", int'(bus.pwm_out), 1);
    chk("idle_cnt", int'(bus.cnt), 0);
    chk("idle_pending", int'(bus.pending), 0);
    chk("idle_pe", int'(bus.period_end), 0);
    bus.polarity = 1'b0;
    start(4, 2);
    run(10, 4, 2, 0, 0);
    bus.period = 8'd9;
    bus.duty = 8'd7;
    bus.load = 1'b1;
    run(1, 4, 2, 0, 0);
    bus.load = 1'b0;
    chk("pend_set", int'(bus.pending), 1);
    run(3, 4, 2, 0, 1);
    chk("pend_hold", int'(bus.pending), 1);
    run(1, 4, 2, 0, 4);
    chk("pend_clr", int'(bus.pending), 0);
    run(20, 9, 7, 0, 0);
    start(9, 0);
    run(12, 9, 0, 0, 0);
    start(99, 200);
    run(105, 99, 200, 0, 0);
    start(0, 5);
    run(4, 0, 5, 0, 0);
    bus.polarity = 1'b1;
    start(4, 2);
    run(7, 4, 2, 1, 0);
    bus.polarity = 1'b0;
    start(3, 1);
    e = 0;
    pe_n = 0;
    for (int c = 0; c < 26; c++) begin
      int prev;
      int w;
      prev = e;
      bus.tick = (c % 3 == 0);
      step();
      w = int'(bus.tick && prev == 3);
      e = bus.tick ? (w != 0 ? 0 : e + 1) : e;
      chk("tk_pwm", int'(bus.pwm_out), int'(prev < 1));
      chk("tk_cnt", int'(bus.cnt), e);
      chk("tk_pe", int'(bus.period_end), w);
      if (bus.period_end && pe_n < 2) begin
        pe_c[pe_n] = c;
        pe_n++;
      end
    end
    chk("tk_pe_count", pe_n, 2);
    chk("tk_gap", pe_c[1] - pe_c[0], 12);
    bus.en = 1'b0;
    bus.polarity = 1'b1;
    bus.tick = 1'b1;
    step();
    chk("exit_cnt", int'(bus.cnt), 0);
    chk("exit_pe", int'(bus.period_end), 0);
    step();
    chk("exit_pwm", int'(bus.pwm_out), 1);
    chk("exit_cnt2", int'(bus.cnt), 0);
    bus.polarity = 1'b0;
    start(4, 2);
    run(4, 4, 2, 0, 0);
    bus.period = 8'd9;
    bus.duty = 8'd7;
    bus.load = 1'b1;
    run(1, 4, 2, 0, 4);
    bus.load = 1'b0;
    chk("wrap_load_pend", int'(bus.pending), 1);
    run(5, 4, 2, 0, 0);
    chk("wrap_load_applied", int'(bus.pending), 0);
    run(10, 9, 7, 0, 0);
    run(3, 9, 7, 0, 0);
    bus.period = 8'd3;
    bus.duty = 8'd3;
    bus.load = 1'b1;
    rst = 1'b1;
    step();
    chk("mid_rst_cnt", int'(bus.cnt), 0);
    chk("mid_rst_pwm", int'(bus.pwm_out), 0);
    chk("mid_rst_pe", int'(bus.period_end), 0);
    chk("mid_rst_pending", int'(bus.pending), 0);
    rst = 1'b0;
    bus.load = 1'b0;
    step();
    chk("post_rst_pwm", int'(bus.pwm_out), 0);
    run(5, 255, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_core.md
# pwm_core

Counter/comparator stage of the PWM signal generator, directly downstream of `mux_prescaler`. It consumes the selected prescaler tick and advances a period counter once per tick. It compares the count against a duty threshold and drives the PWM output. Period and duty use double buffering, so new values take effect only on a period boundary and never produce a glitched cycle.

## Interface
Parameters:
- `WIDTH`, 8: width of counter, period and duty.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable; low forces IDLE.
- `tick`  in  1  count enable from `mux_prescaler` `y`; one-`clk`-wide pulse, or tied high for divide-by-1.
- `period`  in  WIDTH  requested period minus one, in ticks.
- `duty`  in  WIDTH  requested high-time, in ticks.
- `load`  in  1  one-cycle strobe; captures `period`/`duty` into the pending registers.
- `polarity`  in  1  0 = active-high output, 1 = inverted.
- `pwm_out`  out  1  registered PWM output.
- `cnt`  out  WIDTH  current counter value.
- `period_end`  out  1  one-cycle pulse on counter wrap.
- `pending`  out  1  new values are waiting for a boundary.

## Operation
- Registers:
  - pending set: `per_p`, `duty_p`, `pend`.
  - active set: `per_a`, `duty_a`.
  - `cnt`, `state`, `pwm_out`, `period_end`.
- Reset values:
  - `cnt`=0, `per_a`=all ones, `duty_a`=0, `per_p`=0, `duty_p`=0, `pend`=0.
  - `pwm_out`=0, `period_end`=0, state IDLE.
- `load`=1: `per_p<=period`, `duty_p<=duty`, `pend<=1`. Accepted in any state. A later load overwrites an earlier unapplied one.
- IDLE:
  - Holds `cnt`=0.
  - Drives `pwm_out<=polarity`, the inactive level.
  - Ignores `tick`.
  - On `en`=1 goes to RUN. On that transition, if `pend`: copy pending to active and clear `pend`.
- RUN:
  - On `tick`=1 with `cnt==per_a`: `cnt<=0`, `period_end<=1`. If `pend`: copy pending to active and clear `pend`.
  - On `tick`=1 otherwise: `cnt<=cnt+1`.
  - On `tick`=0: `cnt` holds, `period_end<=0`.
- RUN exit: `en`=0 returns to IDLE next cycle and sets `cnt<=0`. Active values are kept and `pend` is kept.
- Compare: `raw = (cnt < duty_a)`, unsigned, WIDTH bits. Each clock in RUN: `pwm_out <= raw ^ polarity`.
- Period length is `per_a+1` ticks.
- Duty limits:
  - `duty_a`=0 gives a constant inactive level.
  - `duty_a > per_a` gives a constant active level (100 %).
- `per_a`=0 means `cnt` stays 0 and `period_end` pulses on every tick.
- `load` coinciding with a boundary or the IDLE→RUN transition:
  - the boundary uses the previous pending contents (or none);
  - the new values stay pending until the next boundary.
- `rst` overrides everything, including `load` and `en`.
- `polarity` is sampled live; it is not double-buffered.

## Timing
- `pwm_out` lags `cnt` by one `clk`: it reflects the compare of the `cnt` value present in the previous cycle.
- `period_end` asserts in the clock after the wrapping tick, coincident with `cnt`=0. It is exactly one `clk` wide.
- Active values switch in the same edge as the wrap. The first compare against the new `duty_a` occurs at `cnt`=0.
- `pending` is the `pend` register; it deasserts on the edge that applies the values.
- With `tick` tied high, one count per `clk`. Otherwise one count per tick pulse, with no internal edge detection.

## Structure
- Shared package `pwm_pkg`:
  - state encoding constants `ST_IDLE`, `ST_RUN`;
  - default `WIDTH`.
  - The prescaler select encoding used by `mux_prescaler` also belongs here.
- Natural sub-module `pwm_shadow_regs` holds the pending/active register pair. Interface: `load`, `apply`, `pend`, `per_a`, `duty_a`.
- Counter, FSM and comparator stay in `pwm_core`.

## Test plan
- Reset, `en`=0, `polarity`=1 → one clk after reset `pwm_out`=1, `cnt`=0, `pending`=0. During reset `pwm_out`=0.
- `load` with `period`=4, `duty`=2, then `en`=1, `tick`=1, `polarity`=0:
  - `pwm_out` repeats 1,1,0,0,0 (period 5 clk);
  - `period_end` pulses every 5 clk when `cnt`=0.
- Running at 4/2, `load` `period`=9, `duty`=7 mid-period:
  - `pending`=1 until the next wrap;
  - the old pattern completes;
  - then 10-clk periods with 7 high.
- `duty`=0 → `pwm_out` constantly 0. `duty`=200 with `period`=99 → constantly 1. `period`=0 → `period_end` every tick.
- `tick` pulsing every 3rd clk, `period`=3, `duty`=1 → `cnt` advances only on ticks and the period is 12 clk. Deassert `en` mid-period → next clk IDLE, `cnt`=0, `pwm_out`=`polarity`.
- `load` asserted on the exact wrap cycle → old values are used for the next period and the new values apply one period later. `rst` asserted mid-run → all registers return to their reset values on the next edge.
